level_fifo: RTL and testbench
=============================

Name: level_fifo

Overview:
- Parametrised synchronous FIFO; next generation of the UART interface byte FIFO.
- Data width follows DBITS end to end. Adds an occupancy count, programmable almost-full/almost-empty thresholds, flush, and sticky overflow/underflow flags.
- Selectable read mode: first-word-fall-through or registered read.
- Sits between the UART RX/TX engines and the debug-module bridge; one instance per direction.

Parameters:
- ABITS, 4, address bits; depth = 2**ABITS, all slots usable; ABITS >= 1.
- DBITS, 8, data word width.
- AFULL_THR, 2**ABITS-2, ALMOST_FULL_O asserts when count >= AFULL_THR.
- AEMPTY_THR, 1, ALMOST_EMPTY_O asserts when count <= AEMPTY_THR.
- FWFT, 1, 1 = head word visible combinationally on R_DATA_O; 0 = registered read, data one cycle after accepted RE_I.

Ports:
- CLK_I  in  1  clock, rising edge.
- RST_I  in  1  synchronous reset, active-high.
- FLUSH_I  in  1  synchronous empty-out, one-cycle pulse.
- WE_I  in  1  write request.
- W_DATA_I  in  DBITS  write data.
- RE_I  in  1  read request.
- R_DATA_O  out  DBITS  read data.
- R_VALID_O  out  1  FWFT=1: equals ~EMPTY_O; FWFT=0: one-cycle pulse, R_DATA_O valid.
- FULL_O  out  1  count == 2**ABITS.
- EMPTY_O  out  1  count == 0.
- ALMOST_FULL_O  out  1  count >= AFULL_THR.
- ALMOST_EMPTY_O  out  1  count <= AEMPTY_THR.
- COUNT_O  out  ABITS+1  occupancy, 0 .. 2**ABITS.
- OVERFLOW_O  out  1  sticky: write attempted and rejected.
- UNDERFLOW_O  out  1  sticky: read attempted on empty.
- CLR_ERR_I  in  1  clears both sticky flags.

Behaviour:
- Priority: RST_I > FLUSH_I > normal operation. All state is updated on the rising edge of CLK_I.
- Reset values:
  - w_ptr = r_ptr = 0, count = 0.
  - EMPTY_O = 1, ALMOST_EMPTY_O = 1, FULL_O = 0, ALMOST_FULL_O = 0.
  - OVERFLOW_O = UNDERFLOW_O = 0, R_VALID_O = 0 (FWFT=0), R_DATA_O register = 0.
  - RAM contents are not reset.
- Status outputs are decoded from the registered count only; no combinational path from WE_I/RE_I to any status output.
- Accept rules, evaluated on pre-edge state:
  - wr_ok = WE_I & (~full | RE_I).
  - rd_ok = RE_I & ~empty.
  - Full with WE_I and RE_I together: both accepted, count unchanged.
  - Empty with WE_I and RE_I together: write accepted, read rejected, UNDERFLOW set, count becomes 1.
- Pointers wrap modulo 2**ABITS (natural ABITS-bit overflow).
- count_next = count + wr_ok - rd_ok.
- Write: RAM[w_ptr] <= W_DATA_I on wr_ok; zero write latency. A word is readable the cycle after it is written; there is no same-cycle bypass.
- FWFT=1 read: R_DATA_O = RAM[r_ptr] combinationally. Value is undefined/stale when empty and must not be checked.
- FWFT=0 read: on rd_ok, R_DATA_O register <= RAM[r_ptr] and R_VALID_O = 1 in the next cycle. Otherwise R_VALID_O = 0 and R_DATA_O holds its value.
- OVERFLOW_O sets on WE_I & ~wr_ok. UNDERFLOW_O sets on RE_I & empty.
- CLR_ERR_I clears both flags; a set condition in the same cycle wins.
- FLUSH_I:
  - Next cycle: pointers and count = 0, R_VALID_O = 0.
  - WE_I/RE_I in the flush cycle are ignored and raise no flags.
  - Sticky flags are untouched.
- Reset mid-transfer: any write/read in the reset cycle is discarded; state as above.
- Thresholds are checked at elaboration: 0 < AFULL_THR <= 2**ABITS, AEMPTY_THR < 2**ABITS; violation is a fatal assertion.

Decomposition:
- Package level_fifo_pkg: read-mode constants (MODE_FWFT, MODE_REG), count/pointer width helper functions, threshold-check function.
- One sub-module fifo_ram: 2**ABITS x DBITS, synchronous write port, asynchronous read port. The FWFT=0 output register lives in level_fifo.

Test Plan (ABITS=2, DBITS=8, AFULL_THR=3, AEMPTY_THR=1):
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> COUNT_O 1,2,3,4; ALMOST_FULL_O from count 3; FULL_O at 4; 5th write 0x55 -> OVERFLOW_O=1, count stays 4.
- From full, WE_I=RE_I=1 with 0x66 -> count stays 4; drain yields 0x22, 0x33, 0x44, 0x66; EMPTY_O=1 after the last read.
- Empty, RE_I=1 with WE_I=1 (0xA5) -> UNDERFLOW_O=1, COUNT_O=1. In FWFT=1, R_DATA_O=0xA5 the next cycle. Then CLR_ERR_I -> both flags 0.
- FWFT=0: write 0x10, 0x20; assert RE_I twice -> R_VALID_O pulses one cycle after each RE_I with R_DATA_O 0x10 then 0x20.
- Ten writes and ten reads interleaved to force pointer wrap -> output order equals input order; no flag raised.
- At count 3, FLUSH_I together with WE_I -> COUNT_O=0, EMPTY_O=1, no OVERFLOW. Then RST_I mid-stream -> all outputs at reset values the following cycle.

Source files
------------

// File: rtl/level_fifo_pkg.sv
// level_fifo_pkg
// Shared constants and elaboration helpers for level_fifo.
//   MODE_FWFT / MODE_REG : read-mode selectors (FWFT parameter values)
//   count_width()        : width of the occupancy counter (0 .. 2**ABITS)
//   ptr_width()          : width of the read/write pointers
//   thr_ok()             : legality check for the almost-full/empty thresholds
package level_fifo_pkg;

  localparam bit MODE_FWFT = 1'b1;
  localparam bit MODE_REG  = 1'b0;

  function automatic int count_width(input int abits);
    return abits + 1;
  endfunction

  function automatic int ptr_width(input int abits);
    return abits;
  endfunction

  function automatic bit thr_ok(input int abits, input int afull_thr, input int aempty_thr);
    return (abits >= 1) && (afull_thr > 0) && (afull_thr <= (2 ** abits)) &&
           (aempty_thr < (2 ** abits));
  endfunction

endpackage

// File: rtl/level_fifo_if.sv
// level_fifo_if
// Bundles the FIFO data path, control strobes and status flags.
//   master : producer/consumer side (drives WE_I, W_DATA_I, RE_I, FLUSH_I, CLR_ERR_I)
//   slave  : FIFO side (drives read data, valid, and all status outputs)
interface level_fifo_if #(
  parameter int ABITS = 4,
  parameter int DBITS = 8
);

  logic             FLUSH_I;
  logic             WE_I;
  logic [DBITS-1:0] W_DATA_I;
  logic             RE_I;
  logic [DBITS-1:0] R_DATA_O;
  logic             R_VALID_O;
  logic             FULL_O;
  logic             EMPTY_O;
  logic             ALMOST_FULL_O;
  logic             ALMOST_EMPTY_O;
  logic [ABITS:0]   COUNT_O;
  logic             OVERFLOW_O;
  logic             UNDERFLOW_O;
  logic             CLR_ERR_I;

  modport master (
    output FLUSH_I, WE_I, W_DATA_I, RE_I, CLR_ERR_I,
    input  R_DATA_O, R_VALID_O, FULL_O, EMPTY_O, ALMOST_FULL_O, ALMOST_EMPTY_O,
           COUNT_O, OVERFLOW_O, UNDERFLOW_O
  );

  modport slave (
    input  FLUSH_I, WE_I, W_DATA_I, RE_I, CLR_ERR_I,
    output R_DATA_O, R_VALID_O, FULL_O, EMPTY_O, ALMOST_FULL_O, ALMOST_EMPTY_O,
           COUNT_O, OVERFLOW_O, UNDERFLOW_O
  );

endinterface

// File: rtl/level_fifo_ram.sv
// fifo_ram
// 2**ABITS x DBITS storage: synchronous write, asynchronous read.
//   CLK_I   : clock
//   we      : write enable
//   w_addr  : write address
//   w_data  : write data
//   r_addr  : read address
//   r_data  : read data (combinational from r_addr)
module fifo_ram #(
  parameter int ABITS = 4,
  parameter int DBITS = 8
) (
  input  logic             CLK_I,
  input  logic             we,
  input  logic [ABITS-1:0] w_addr,
  input  logic [DBITS-1:0] w_data,
  input  logic [ABITS-1:0] r_addr,
  output logic [DBITS-1:0] r_data
);

  logic [DBITS-1:0] mem [2**ABITS];

  always_ff @(posedge CLK_I) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/level_fifo.sv
// level_fifo
// Parametrised synchronous FIFO with occupancy count, almost-full/empty
// thresholds, flush, sticky overflow/underflow flags and a selectable
// read mode (first-word-fall-through or registered read).
//   CLK_I : clock, rising edge
//   RST_I : synchronous reset, active-high (wins over flush)
//   fifo  : level_fifo_if.slave -- write/read strobes, data, flush,
//           error clear, and all status outputs
module level_fifo
  import level_fifo_pkg::*;
#(
  parameter int ABITS      = 4,
  parameter int DBITS      = 8,
  parameter int AFULL_THR  = 2 ** ABITS - 2,
  parameter int AEMPTY_THR = 1,
  parameter int FWFT       = 1
) (
  input logic        CLK_I,
  input logic        RST_I,
  level_fifo_if.slave fifo
);

  localparam int  CW        = count_width(ABITS);
  localparam int  PW        = ptr_width(ABITS);
  localparam int  DEPTH     = 2 ** ABITS;
  localparam bit  READ_MODE = (FWFT != 0) ? MODE_FWFT : MODE_REG;

  generate
    if (!thr_ok(ABITS, AFULL_THR, AEMPTY_THR)) begin : g_thr_fail
      $fatal(1, "level_fifo: AFULL_THR/AEMPTY_THR out of range for ABITS");
    end
  endgenerate

  logic [PW-1:0]    w_ptr;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;
  logic             ram_we;
  logic [DBITS-1:0] ram_rdata;
  logic [DBITS-1:0] rdata_q;
  logic             rvalid_q;
  logic             overflow_q;
  logic             underflow_q;

  // Status comes from the registered count only, so nothing here depends
  // combinationally on WE_I/RE_I.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A write into a full FIFO is allowed when a read frees a slot in the
  // same cycle; a read on empty is never accepted, even alongside a write.
  assign wr_ok = fifo.WE_I & (~full | fifo.RE_I);
  assign rd_ok = fifo.RE_I & ~empty;

  assign ram_we = wr_ok & ~fifo.FLUSH_I & ~RST_I;

  fifo_ram #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_ram (
    .CLK_I  (CLK_I),
    .we     (ram_we),
    .w_addr (w_ptr),
    .w_data (fifo.W_DATA_I),
    .r_addr (r_ptr),
    .r_data (ram_rdata)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      count    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (fifo.FLUSH_I) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      count    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        w_ptr <= w_ptr + PW'(1);
      end
      if (rd_ok) begin
        r_ptr   <= r_ptr + PW'(1);
        rdata_q <= ram_rdata;
      end
      rvalid_q <= rd_ok;
      count    <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // Sticky error flags: a set condition in the same cycle beats CLR_ERR_I;
  // flush leaves them alone.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!fifo.FLUSH_I) begin
      if (fifo.WE_I && !wr_ok) begin
        overflow_q <= 1'b1;
      end else if (fifo.CLR_ERR_I) begin
        overflow_q <= 1'b0;
      end
      if (fifo.RE_I && empty) begin
        underflow_q <= 1'b1;
      end else if (fifo.CLR_ERR_I) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign fifo.R_DATA_O       = (READ_MODE == MODE_FWFT) ? ram_rdata : rdata_q;
  assign fifo.R_VALID_O      = (READ_MODE == MODE_FWFT) ? ~empty : rvalid_q;
  assign fifo.FULL_O         = full;
  assign fifo.EMPTY_O        = empty;
  assign fifo.ALMOST_FULL_O  = (count >= CW'(AFULL_THR));
  assign fifo.ALMOST_EMPTY_O = (count <= CW'(AEMPTY_THR));
  assign fifo.COUNT_O        = count;
  assign fifo.OVERFLOW_O     = overflow_q;
  assign fifo.UNDERFLOW_O    = underflow_q;

endmodule

// File: tb/tb_level_fifo.sv
module tb_level_fifo;

  localparam int ABITS = 2;
  localparam int DBITS = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, we, re, clr;
  logic [7:0] wd;

  always #5 clk = ~clk;

  level_fifo_if #(.ABITS(ABITS), .DBITS(DBITS)) bus_f ();
  level_fifo_if #(.ABITS(ABITS), .DBITS(DBITS)) bus_r ();

  assign bus_f.FLUSH_I = flush;  assign bus_r.FLUSH_I = flush;
  assign bus_f.WE_I = we;        assign bus_r.WE_I = we;
  assign bus_f.W_DATA_I = wd;    assign bus_r.W_DATA_I = wd;
  assign bus_f.RE_I = re;        assign bus_r.RE_I = re;
  assign bus_f.CLR_ERR_I = clr;  assign bus_r.CLR_ERR_I = clr;

  level_fifo #(.ABITS(ABITS), .DBITS(DBITS), .AFULL_THR(3), .AEMPTY_THR(1), .FWFT(1))
    dut_f (.CLK_I(clk), .RST_I(rst), .fifo(bus_f));
  level_fifo #(.ABITS(ABITS), .DBITS(DBITS), .AFULL_THR(3), .AEMPTY_THR(1), .FWFT(0))
    dut_r (.CLK_I(clk), .RST_I(rst), .fifo(bus_r));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Behavioural model: a queue of accepted words plus flags.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0, m_unf = 1'b0;
  bit         m_rv = 1'b0;
  logic [7:0] m_rd = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0; m_rd = 8'h00;
    end else if (flush) begin
      q.delete();
      m_rv = 1'b0;
    end else begin
      automatic bit is_full  = (q.size() == DEPTH);
      automatic bit is_empty = (q.size() == 0);
      automatic bit wok = we && (!is_full || re);
      automatic bit rok = re && !is_empty;
      if (we && !wok) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (re && is_empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
      if (rok) begin
        m_rd = q.pop_front();
        m_rv = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
      if (wok) q.push_back(wd);
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count_f", 32'(bus_f.COUNT_O), 32'(q.size()));
      chk("count_r", 32'(bus_r.COUNT_O), 32'(q.size()));
      chk("empty", {30'd0, bus_r.EMPTY_O, bus_f.EMPTY_O}, {30'd0, {2{q.size() == 0}}});
      chk("full", {30'd0, bus_r.FULL_O, bus_f.FULL_O}, {30'd0, {2{q.size() == DEPTH}}});
      chk("afull", {30'd0, bus_r.ALMOST_FULL_O, bus_f.ALMOST_FULL_O},
          {30'd0, {2{q.size() >= 3}}});
      chk("aempty", {30'd0, bus_r.ALMOST_EMPTY_O, bus_f.ALMOST_EMPTY_O},
          {30'd0, {2{q.size() <= 1}}});
      chk("ovf", {30'd0, bus_r.OVERFLOW_O, bus_f.OVERFLOW_O}, {30'd0, {2{m_ovf}}});
      chk("unf", {30'd0, bus_r.UNDERFLOW_O, bus_f.UNDERFLOW_O}, {30'd0, {2{m_unf}}});
      chk("rvalid_f", 32'(bus_f.R_VALID_O), 32'(q.size() != 0));
      if (q.size() != 0) chk("rdata_f", 32'(bus_f.R_DATA_O), 32'(q[0]));
      chk("rvalid_r", 32'(bus_r.R_VALID_O), 32'(m_rv));
      chk("rdata_r", 32'(bus_r.R_DATA_O), 32'(m_rd));
    end
  end

  task automatic step(input bit we_v, input logic [7:0] wd_v, input bit re_v,
                      input bit fl_v, input bit clr_v, input bit rst_v);
    we = we_v; wd = wd_v; re = re_v; flush = fl_v; clr = clr_v; rst = rst_v;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; flush = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(bus_f.COUNT_O), 32'd0);
    chk({tag, "_empty"}, 32'(bus_f.EMPTY_O), 32'd1);
    chk({tag, "_aempty"}, 32'(bus_f.ALMOST_EMPTY_O), 32'd1);
    chk({tag, "_full"}, 32'(bus_f.FULL_O), 32'd0);
    chk({tag, "_afull"}, 32'(bus_f.ALMOST_FULL_O), 32'd0);
    chk({tag, "_flags"}, {30'd0, bus_f.OVERFLOW_O, bus_f.UNDERFLOW_O}, 32'd0);
    chk({tag, "_rvalid_r"}, 32'(bus_r.R_VALID_O), 32'd0);
    chk({tag, "_rdata_r"}, 32'(bus_r.R_DATA_O), 32'd0);
  endtask

  initial begin
    logic [7:0] drain [4];
    drain[0] = 8'h22; drain[1] = 8'h33; drain[2] = 8'h44; drain[3] = 8'h66;
    we = 0; re = 0; flush = 0; clr = 0; rst = 1; wd = 0;
    #1;
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk_en = 1'b1;
    chk_reset_state("reset");

    // Fill to full, then overflow.
    step(1, 8'h11, 0, 0, 0, 0); chk("fill1_count", 32'(bus_f.COUNT_O), 32'd1);
    step(1, 8'h22, 0, 0, 0, 0); chk("fill2_count", 32'(bus_f.COUNT_O), 32'd2);
    chk("fill2_afull", 32'(bus_f.ALMOST_FULL_O), 32'd0);
    step(1, 8'h33, 0, 0, 0, 0); chk("fill3_afull", 32'(bus_f.ALMOST_FULL_O), 32'd1);
    chk("fill3_full", 32'(bus_f.FULL_O), 32'd0);
    step(1, 8'h44, 0, 0, 0, 0); chk("fill4_full", 32'(bus_f.FULL_O), 32'd1);
    chk("fill4_count", 32'(bus_f.COUNT_O), 32'd4);
    step(1, 8'h55, 0, 0, 0, 0); chk("ovf_set", 32'(bus_f.OVERFLOW_O), 32'd1);
    chk("ovf_count", 32'(bus_f.COUNT_O), 32'd4);

    // Simultaneous write/read when full.
    step(1, 8'h66, 1, 0, 0, 0); chk("full_rw_count", 32'(bus_f.COUNT_O), 32'd4);
    chk("full_rw_rdata_r", 32'(bus_r.R_DATA_O), 32'h11);
    for (int i = 0; i < 4; i++) begin
      chk("drain_head_f", 32'(bus_f.R_DATA_O), 32'(drain[i]));
      step(0, 8'h00, 1, 0, 0, 0);
      chk("drain_rvalid_r", 32'(bus_r.R_VALID_O), 32'd1);
      chk("drain_rdata_r", 32'(bus_r.R_DATA_O), 32'(drain[i]));
    end
    chk("drain_empty", 32'(bus_f.EMPTY_O), 32'd1);

    // Read+write on empty: underflow, write still lands.
    step(0, 8'h00, 0, 0, 1, 0); chk("clr_ovf", 32'(bus_f.OVERFLOW_O), 32'd0);
    step(1, 8'hA5, 1, 0, 0, 0);
    chk("unf_set", 32'(bus_f.UNDERFLOW_O), 32'd1);
    chk("unf_count", 32'(bus_f.COUNT_O), 32'd1);
    chk("unf_rdata_f", 32'(bus_f.R_DATA_O), 32'hA5);
    step(0, 8'h00, 0, 0, 1, 0);
    chk("clr_both", {30'd0, bus_f.OVERFLOW_O, bus_f.UNDERFLOW_O}, 32'd0);
    step(0, 8'h00, 1, 0, 0, 0);

    // Registered-read latency.
    step(1, 8'h10, 0, 0, 0, 0);
    step(1, 8'h20, 0, 0, 0, 0);
    chk("reg_idle_rvalid", 32'(bus_r.R_VALID_O), 32'd0);
    step(0, 8'h00, 1, 0, 0, 0);
    chk("reg_rd1", {23'd0, bus_r.R_VALID_O, bus_r.R_DATA_O}, 32'h110);
    step(0, 8'h00, 1, 0, 0, 0);
    chk("reg_rd2", {23'd0, bus_r.R_VALID_O, bus_r.R_DATA_O}, 32'h120);
    step(0, 8'h00, 0, 0, 0, 0);
    chk("reg_hold", {23'd0, bus_r.R_VALID_O, bus_r.R_DATA_O}, 32'h020);

    // Pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(1, 8'(8'h80 + i), 0, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0, 0);
      chk("wrap_rdata_r", 32'(bus_r.R_DATA_O), 32'(8'h80 + i));
    end
    chk("wrap_flags", {30'd0, bus_f.OVERFLOW_O, bus_f.UNDERFLOW_O}, 32'd0);

    // Flush with a write in the same cycle.
    step(1, 8'h01, 0, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0, 0);
    chk("pre_flush_count", 32'(bus_f.COUNT_O), 32'd3);
    step(1, 8'h04, 0, 1, 0, 0);
    chk("flush_count", 32'(bus_f.COUNT_O), 32'd0);
    chk("flush_empty", 32'(bus_f.EMPTY_O), 32'd1);
    chk("flush_ovf", 32'(bus_f.OVERFLOW_O), 32'd0);

    // Reset mid-stream.
    step(1, 8'h05, 0, 0, 0, 0);
    step(1, 8'h06, 1, 0, 0, 0);
    step(1, 8'h07, 1, 0, 0, 1);
    chk_reset_state("midrst");

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 55), 8'($urandom), ($urandom_range(99) < 50),
           ($urandom_range(99) < 3), ($urandom_range(99) < 10),
           ($urandom_range(999) < 5));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
